t_7458_sweep_checker: RTL and testbench

//  Self-checking hardware exerciser for the t_7458 dual AND-OR gate.
//  - Drives all 1024 input vectors to the DUT and samples p1y/p2y after a settle window.
//  - Compares each sample against a golden 7458 model and counts mismatches.
//  - Sits beside the t_7458 instance on-board or in simulation, replacing the ad-hoc stimulus loop.

---
 rtl/t7458_chk_pkg.sv | 25 ++
 rtl/t7458_golden_model.sv | 14 +
 rtl/t_7458_sweep_checker.sv | 112 +++++++++++
 tb/tb_t_7458_sweep_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t7458_chk_pkg.sv
// Shared types, widths and golden 7458 equations for the t_7458 sweep checker.
package t7458_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int P1_W  = 6;
  localparam int P2_W  = 4;
  localparam int IDX_W = 10;
  localparam logic [IDX_W-1:0] LAST_IDX = 10'd1023;

  // Bit order is {f,e,d,c,b,a} for p1 and {d,c,b,a} for p2.
  function automatic logic golden_p1y(input logic [P1_W-1:0] p1);
    return (p1[0] & p1[1] & p1[2]) | (p1[3] & p1[4] & p1[5]);
  endfunction

  function automatic logic golden_p2y(input logic [P2_W-1:0] p2);
    return (p2[0] & p2[1]) | (p2[2] & p2[3]);
  endfunction

endpackage

// File: rtl/t7458_golden_model.sv
// Combinational reference 7458: maps the current vector to the expected p1y/p2y.
module t7458_golden_model
  import t7458_chk_pkg::*;
(
  input  logic [P1_W-1:0] p1,
  input  logic [P2_W-1:0] p2,
  output logic            exp_p1y,
  output logic            exp_p2y
);

  assign exp_p1y = golden_p1y(p1);
  assign exp_p2y = golden_p2y(p2);

endmodule

// File: rtl/t_7458_sweep_checker.sv
// Exhaustive 1024-vector sweep checker for a t_7458 dual AND-OR gate.
// Define T7458_CHK_CAPTURE_EN to add fail_valid/fail_vec first-failure capture.
module t_7458_sweep_checker
  import t7458_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [10:0]      err_count,
  output logic [P1_W-1:0]  p1_out,
  output logic [P2_W-1:0]  p2_out,
  input  logic             p1y_in,
  input  logic             p2y_in,
`ifdef T7458_CHK_CAPTURE_EN
  output logic             fail_valid,
  output logic [IDX_W-1:0] fail_vec,
`endif
  output logic [1:0]       fsm_state
);

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [7:0]       cnt;
  logic             exp_p1y;
  logic             exp_p2y;
  logic             mismatch;
  logic             start_ok;

  t7458_golden_model u_golden (
    .p1      (idx[P1_W-1:0]),
    .p2      (idx[IDX_W-1:P1_W]),
    .exp_p1y (exp_p1y),
    .exp_p2y (exp_p2y)
  );

  assign mismatch  = (p1y_in != exp_p1y) || (p2y_in != exp_p2y);
  // A start pulse only counts when no sweep is running.
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign idx_next  = idx + 10'd1;
  assign busy      = (state == SETTLE) || (state == CHECK);
  assign pass      = done && (err_count == 11'd0);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      err_count <= '0;
      p1_out    <= '0;
      p2_out    <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SETTLE;
            idx       <= '0;
            cnt       <= '0;
            err_count <= '0;
            p1_out    <= '0;
            p2_out    <= '0;
            done      <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 8'd1;
          if (cnt == CNT_LAST) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) err_count <= err_count + 11'd1;
          if (idx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            // Vector outputs advance together with idx so they always match it.
            idx    <= idx_next;
            p1_out <= idx_next[P1_W-1:0];
            p2_out <= idx_next[IDX_W-1:P1_W];
            cnt    <= '0;
            state  <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef T7458_CHK_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (state == CHECK && mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= idx;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_t_7458_sweep_checker.sv
// Bench for t_7458_sweep_checker: emulated 7458 with fault modes, time-based sweep model.
module tb_t_7458_sweep_checker;

  localparam int S       = 2;
  localparam int VEC_CYC = S + 1;
  localparam int SWEEP   = 1024 * VEC_CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        pass;
  logic [10:0] err_count;
  logic [5:0]  p1_out;
  logic [3:0]  p2_out;
  logic        p1y_in;
  logic        p2y_in;
  logic [1:0]  fsm_state;
`ifdef T7458_CHK_CAPTURE_EN
  logic        fail_valid;
  logic [9:0]  fail_vec;
`endif

  int   total = 0;
  int   bad   = 0;
  int   mode  = 0;
  logic flip1 [1024];
  logic flip2 [1024];
  int   nxt_pre   [1025];
  int   nxt_first [1025];
  int   cur_pre   [1025];
  int   cur_first [1025];
  int   lat;

  t_7458_sweep_checker #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .p1_out     (p1_out),
    .p2_out     (p2_out),
    .p1y_in     (p1y_in),
    .p2y_in     (p2y_in),
`ifdef T7458_CHK_CAPTURE_EN
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec),
`endif
    .fsm_state  (fsm_state)
  );

  always #5 clk = ~clk;

  // Golden 7458 from the vector index: p1y needs abc or def all high, p2y needs ab or cd.
  function automatic logic ref_p1y(input int j);
    return ((j % 8) == 7) || (((j / 8) % 8) == 7);
  endfunction

  function automatic logic ref_p2y(input int j);
    return (((j / 64) % 4) == 3) || (((j / 256) % 4) == 3);
  endfunction

  // Emulated gate under test: mode 0 good, 1 p1y stuck 0, 2 p2y stuck 0, 3 p1y stuck 1, 4 random flips.
  function automatic logic resp1(input int j, input int m, input logic f);
    case (m)
      1:       return 1'b0;
      3:       return 1'b1;
      4:       return ref_p1y(j) ^ f;
      default: return ref_p1y(j);
    endcase
  endfunction

  function automatic logic resp2(input int j, input int m, input logic f);
    case (m)
      2:       return 1'b0;
      4:       return ref_p2y(j) ^ f;
      default: return ref_p2y(j);
    endcase
  endfunction

  assign p1y_in = resp1(int'({p2_out, p1_out}), mode, flip1[{p2_out, p1_out}]);
  assign p2y_in = resp2(int'({p2_out, p1_out}), mode, flip2[{p2_out, p1_out}]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_mode(input int m);
    logic mm;
    mode = m;
    for (int j = 0; j < 1024; j++) begin
      flip1[j] = (m == 4) && ($urandom_range(0, 15) == 0);
      flip2[j] = (m == 4) && ($urandom_range(0, 15) == 0);
    end
    nxt_pre[0]   = 0;
    nxt_first[0] = -1;
    for (int j = 0; j < 1024; j++) begin
      mm = (resp1(j, m, flip1[j]) != ref_p1y(j)) || (resp2(j, m, flip2[j]) != ref_p2y(j));
      nxt_pre[j+1]   = nxt_pre[j] + int'(mm);
      nxt_first[j+1] = (nxt_first[j] >= 0) ? nxt_first[j] : (mm ? j : -1);
    end
  endtask

  // Reference: outputs as a function of cycles elapsed since the accepted start.
  initial begin : compare
    bit m_valid, m_run, m_done, rs, ss;
    int m_t, k, vec, e_err, e_first;
    logic [63:0] act, exp;
    m_valid = 0; m_run = 0; m_done = 0; m_t = 0;
    forever begin
      @(posedge clk);
      rs = rst;
      ss = start;
      if (rs) begin
        m_valid = 1; m_run = 0; m_done = 0;
      end else if (ss && !m_run) begin
        m_run = 1; m_done = 0; m_t = 0;
        cur_pre   = nxt_pre;
        cur_first = nxt_first;
      end else if (m_run) begin
        m_t++;
        if (m_t == SWEEP) begin
          m_run = 0; m_done = 1;
        end
      end
      #1;
      if (m_valid) begin
        k       = m_run ? m_t / VEC_CYC : 1024;
        vec     = m_run ? k : (m_done ? 1023 : 0);
        e_err   = m_run ? cur_pre[k] : (m_done ? cur_pre[1024] : 0);
        e_first = m_run ? cur_first[k] : (m_done ? cur_first[1024] : -1);
        exp = {40'd0, m_run, m_done, (m_done && e_err == 0), 11'(e_err), 10'(vec)};
        act = {40'd0, busy, done, pass, err_count, p2_out, p1_out};
`ifdef T7458_CHK_CAPTURE_EN
        exp[34:24] = {(e_first >= 0), (e_first >= 0) ? 10'(e_first) : 10'd0};
        act[34:24] = {fail_valid, fail_vec};
`endif
        check("cycle", act, exp);
      end
    end
  end

  task automatic sweep(input int inj, output int l);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l = 1;
    while (!done && l < SWEEP + 50) begin
      start = (l == inj);
      @(negedge clk);
      l++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
  endtask

  initial begin : stim
    rst = 1'b1;
    start = 1'b0;
    set_mode(0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_count, 11'd0);
    check("rst_vec", {p2_out, p1_out}, 10'd0);

    // Good gate.
    sweep(-1, lat);
    check("t1_latency", lat, 3073);
    check("t1_err", err_count, 11'd0);
    check("t1_pass", pass, 1'b1);
    check("t1_busy", busy, 1'b0);
    check("t1_vec_hold", {p2_out, p1_out}, 10'd1023);

    // p1y stuck low.
    set_mode(1);
    check("model_t2", nxt_pre[1024], 240);
    sweep(-1, lat);
    check("t2_err", err_count, 11'd240);
    check("t2_pass", pass, 1'b0);

    // p2y stuck low.
    set_mode(2);
    sweep(-1, lat);
    check("t3_err", err_count, 11'd448);
`ifdef T7458_CHK_CAPTURE_EN
    check("t3_fail_vec", fail_vec, 10'd192);
    check("t3_fail_valid", fail_valid, 1'b1);
`endif

    // p1y stuck high.
    set_mode(3);
    sweep(-1, lat);
    check("t4_err", err_count, 11'd784);
`ifdef T7458_CHK_CAPTURE_EN
    check("t4_fail_vec", fail_vec, 10'd0);
`endif

    // Start pulse mid-sweep must be ignored.
    set_mode(0);
    sweep(300, lat);
    check("t5_latency", lat, 3073);
    check("t5_pass", pass, 1'b1);

    // Reset in the middle of a sweep, then a fresh sweep.
    set_mode(1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1500) @(negedge clk);
    check("t6_busy_mid", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_busy_rst", busy, 1'b0);
    check("t6_err_rst", err_count, 11'd0);
    check("t6_vec_rst", {p2_out, p1_out}, 10'd0);
    set_mode(0);
    sweep(-1, lat);
    check("t6_latency", lat, SWEEP + 1);
    check("t6_pass", pass, 1'b1);

    // Random per-vector faults.
    set_mode(4);
    sweep(-1, lat);
    check("t7_err", err_count, 11'(nxt_pre[1024]));
    check("t7_pass", pass, nxt_pre[1024] == 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
